// File: rtl/vga_timing_gen.sv
// Raster timing source: DrawX/DrawY/blank plus active-low hs/vs, line/frame strobes and a
// frame counter. Every output is registered from the same next-pixel values, so they never skew.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       pixel_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_range_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync window ending exactly at 1024 does not wrap to 0
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]  hc_next;
  logic [9:0]  vc_next;
  logic [10:0] hx;
  logic [10:0] vx;
  logic        h_wrap;

  // DrawX/DrawY are the raster counters themselves; no separate hc/vc copies are kept.
  always_comb begin
    h_wrap  = (DrawX == H_LAST);
    hc_next = h_wrap ? 10'd0 : DrawX + 10'd1;
    vc_next = DrawY;
    if (h_wrap) begin
      vc_next = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
    end
    hx = {1'b0, hc_next};
    vx = {1'b0, vc_next};
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
    end else if (pixel_en) begin
      DrawX       <= hc_next;
      DrawY       <= vc_next;
      blank       <= (hx < H_VIS) && (vx < V_VIS);
      hs          <= ~((hx >= HS_START) && (hx < HS_END));
      vs          <= ~((vx >= VS_START) && (vx < VS_END));
      line_start  <= (hc_next == 10'd0);
      frame_start <= (hc_next == 10'd0) && (vc_next == 10'd0);
      if ((hc_next == 10'd0) && (vc_next == 10'd0)) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end else begin
      // strobes are one vga_clk wide even when the pixel rate is divided
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster (15x11) so full frames and the
// 256-frame counter wrap fit in a short run.
module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VV = 6, VF = 1, VSW = 2, VB = 2;
  localparam int HT = 15, VT = 11, PT = 165;
  localparam int HS_FIRST = 10, HS_LAST = 12;
  localparam int VS_FIRST = 7, VS_LAST = 8;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b0;
  logic       pixel_en = 1'b0;
  logic [9:0] DrawX, DrawY;
  logic       blank, hs, vs, line_start, frame_start;
  logic [7:0] frame_cnt;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .pixel_en(pixel_en),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .hs(hs), .vs(vs),
    .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int m_p = PT - 1;
  int m_fc = 0;
  int exp_period = 0;

  // Model tracks a linear pixel index and derives coordinates from it.
  function automatic exp_t expect_of(input int p, input int fc, input bit ls, input bit fs,
                                     input bit rst);
    exp_t e;
    int x, y;
    x = p % HT;
    y = p / HT;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.blank = rst ? 1'b0 : ((x < HV) && (y < VV));
    e.hs    = rst ? 1'b1 : !((x >= HS_FIRST) && (x <= HS_LAST));
    e.vs    = rst ? 1'b1 : !((y >= VS_FIRST) && (y <= VS_LAST));
    e.ls    = ls;
    e.fs    = fs;
    e.fc    = 8'(fc);
    return e;
  endfunction

  task automatic push_model(input bit en, input bit rst);
    bit ls, fs;
    ls = 1'b0;
    fs = 1'b0;
    if (rst) begin
      m_p  = PT - 1;
      m_fc = 0;
    end else if (en) begin
      m_p = (m_p + 1) % PT;
      ls  = (m_p % HT == 0);
      fs  = (m_p == 0);
      if (fs) m_fc = (m_fc + 1) % 256;
    end
    sb.push_back(expect_of(m_p, m_fc, ls, fs, rst));
  endtask

  task automatic cycle(input bit en, input bit rst);
    @(negedge vga_clk);
    pixel_en = en;
    reset    = rst;
    push_model(en, rst);
  endtask

  // Reset asserted between edges: one check right after assertion, one at the next edge.
  task automatic async_reset();
    @(negedge vga_clk);
    push_model(1'b0, 1'b1);
    push_model(1'b0, 1'b1);
    #2 reset = 1'b1;
  endtask

  int cyc = 0;
  int last_fs = -1;
  int cur_period = 0;

  always begin
    exp_t e, g;
    @(posedge vga_clk or posedge reset);
    #1;
    if (vga_clk) cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = '{DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_cnt};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL raster t=%0t: got x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                 $time, g.x, g.y, g.blank, g.hs, g.vs, g.ls, g.fs, g.fc,
                 e.x, e.y, e.blank, e.hs, e.vs, e.ls, e.fs, e.fc);
      end
    end
    if (reset) begin
      last_fs = -1;
    end else if (vga_clk && frame_start === 1'b1) begin
      if (exp_period != cur_period) begin
        cur_period = exp_period;
        last_fs = -1;
      end
      if (last_fs >= 0 && cur_period > 0) begin
        total++;
        if (cyc - last_fs != cur_period) begin
          bad++;
          $display("FAIL frame_period: got %0d cycles, want %0d", cyc - last_fs, cur_period);
        end
      end
      last_fs = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // power-up async reset, release into full-rate raster
    async_reset();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    exp_period = PT;
    for (int i = 0; i < 3 * PT + 20; i++) cycle(1'b1, 1'b0);

    // pixel_en one cycle in four
    exp_period = 4 * PT;
    for (int i = 0; i < 12 * PT; i++) cycle(i % 4 == 0, 1'b0);

    // async reset mid-frame at (5,3)
    exp_period = PT;
    for (int i = 0; i < 2 * PT && m_p != 3 * HT + 5; i++) cycle(1'b1, 1'b0);
    async_reset();
    cycle(1'b1, 1'b1);

    // 256+ frames: frame counter wraps 255 -> 0
    for (int i = 0; i < 256 * PT + 10; i++) cycle(1'b1, 1'b0);

    @(negedge vga_clk);
    @(negedge vga_clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
